// File: rtl/xy_drive_ramp.sv
// X/Y drive output stage: de-interleaves the X/Y word stream, applies a per-frame
// soft-start/soft-stop gain envelope, rounds and saturates to DAC width, with a sync watchdog.
module xy_drive_ramp #(
  parameter int IW        = 18,
  parameter int OW        = 16,
  parameter int GW        = 16,
  parameter int WD_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_sync,
  input  logic signed [IW-1:0] in_xy,
  input  logic                 enable,
  input  logic        [GW-1:0] ramp_step,
  output logic signed [OW-1:0] out_x,
  output logic signed [OW-1:0] out_y,
  output logic                 out_valid,
  output logic        [GW-1:0] gain,
  output logic        [1:0]    state,
  output logic                 wd_fault
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  localparam int PW = IW + GW + 1;
  localparam int CW = $clog2(WD_CYCLES + 1);
  localparam logic [GW-1:0]        GMAX   = '1;
  localparam logic [CW-1:0]        WD_LIM = CW'(WD_CYCLES);
  localparam logic signed [PW-1:0] HALF   = PW'(2 ** (GW - 1));
  localparam logic signed [PW-1:0] LIM    = PW'(2 ** (OW - 1) - 1);

  state_e                 state_q, state_d;
  logic        [GW-1:0]   gain_q, gain_d;
  logic                   cap_q;
  logic                   accept;
  logic signed [IW-1:0]   x_q, y_q;
  logic                   y_vld_q, p_vld_q;
  logic signed [PW-1:0]   px_q, py_q;
  logic signed [PW-1:0]   x_ext, y_ext, g_ext;
  logic signed [OW-1:0]   out_x_q, out_y_q;
  logic                   out_valid_q;
  logic        [CW-1:0]   wd_cnt_q, wd_cnt_d;
  logic                   wd_fault_q, wd_fault_d;
  logic                   wd_force_q, wd_trip;
  logic        [GW:0]     gain_up;
  logic        [GW-1:0]   gain_up_sat, gain_dn;

  // A sync arriving while Y is being captured is data, not a new frame.
  assign accept = in_sync & ~cap_q;

  assign gain_up     = {1'b0, gain_q} + {1'b0, ramp_step};
  assign gain_up_sat = gain_up[GW] ? GMAX : gain_up[GW-1:0];
  assign gain_dn     = (ramp_step >= gain_q) ? '0 : gain_q - ramp_step;

  // NOTE: every variable gets its default at the top of the block, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    if (wd_force_q) begin
      state_d = ST_IDLE;
      gain_d  = '0;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          gain_d = '0;
          if (enable && !wd_fault_q) state_d = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (!enable) begin
            state_d = ST_RAMP_DOWN;
          end else begin
            gain_d = gain_up_sat;
            if (ramp_step != '0 && gain_up_sat == GMAX) state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) state_d = ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          if (enable) begin
            state_d = ST_RAMP_UP;
          end else begin
            gain_d = gain_dn;
            if (ramp_step != '0 && gain_dn == '0) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (accept)                wd_cnt_d = '0;
    else if (wd_cnt_q != WD_LIM) wd_cnt_d = wd_cnt_q + CW'(1);
    wd_trip    = !wd_fault_q && (state_q != ST_IDLE) && (wd_cnt_d == WD_LIM);
    wd_fault_d = wd_fault_q;
    if (wd_trip)      wd_fault_d = 1'b1;
    else if (!enable) wd_fault_d = 1'b0;
  end

  // NOTE: state and datapath registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gain_q     <= '0;
      wd_cnt_q   <= '0;
      wd_fault_q <= 1'b0;
      wd_force_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      wd_cnt_q   <= wd_cnt_d;
      wd_fault_q <= wd_fault_d;
      wd_force_q <= wd_trip;
    end
  end

  assign x_ext = PW'(x_q);
  assign y_ext = PW'(y_q);
  assign g_ext = PW'({1'b0, gain_q});

  function automatic logic signed [OW-1:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + HALF) >>> GW;
    if (r > LIM)       r = LIM;
    else if (r < -LIM) r = -LIM;
    return r[OW-1:0];
  endfunction

  // Pipeline: X at the sync edge, Y one edge later, products, then round/saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      y_vld_q     <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
      p_vld_q     <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cap_q       <= accept & ~wd_force_q;
      y_vld_q     <= cap_q & ~wd_force_q;
      p_vld_q     <= y_vld_q & ~wd_force_q;
      out_valid_q <= p_vld_q & ~wd_force_q;
      if (accept) x_q <= in_xy;
      if (cap_q)  y_q <= in_xy;
      if (y_vld_q) begin
        px_q <= x_ext * g_ext;
        py_q <= y_ext * g_ext;
      end
      if (wd_force_q) begin
        out_x_q <= '0;
        out_y_q <= '0;
      end else if (p_vld_q) begin
        out_x_q <= round_sat(px_q);
        out_y_q <= round_sat(py_q);
      end
    end
  end

  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_valid = out_valid_q;
  assign gain      = gain_q;
  assign state     = state_q;
  assign wd_fault  = wd_fault_q;

endmodule

// File: doc/xy_drive_ramp.md
# xy_drive_ramp

Drive-output stage placed directly downstream of `mp_proc`. It de-interleaves the time-multiplexed X/Y stream (`out_xy`/`out_sync`) into a parallel sample pair and applies a per-frame soft-start/soft-stop gain envelope. It then rounds and saturates the pair to DAC width. A sync watchdog forces the drive to zero if `mp_proc` stops producing frames.

## Interface

Parameters:
- `IW`, 18, input word width (signed)
- `OW`, 16, output word width (signed)
- `GW`, 16, gain width (unsigned); full scale `GMAX = 2^GW-1`
- `WD_CYCLES`, 64, watchdog limit in clocks between accepted syncs

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_sync`  in  1  X word present on `in_xy` this cycle; Y word follows next cycle
- `in_xy`  in  IW  signed interleaved X/Y data
- `enable`  in  1  level; request drive on
- `ramp_step`  in  GW  unsigned gain increment/decrement per accepted frame
- `out_x`, `out_y`  out  OW  signed scaled drive pair
- `out_valid`  out  1  one-cycle strobe when `out_x`/`out_y` update
- `gain`  out  GW  current envelope gain
- `state`  out  2  IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3
- `wd_fault`  out  1  sticky watchdog fault

## Operation

- **Reset:** all outputs 0, state IDLE, capture idle, watchdog count 0.
- **Accepted sync.** `in_sync` is accepted unless a capture is in progress, i.e. `in_sync` was accepted the previous cycle. A rejected sync is ignored entirely: no capture, no gain step, no watchdog clear.
- **Capture.** X is captured at the accepted-sync cycle t, and Y at t+1.
- **Gain update.** Occurs only at the accepted-sync edge, per state:
  - IDLE: gain=0. If `enable` and not `wd_fault`, go to RAMP_UP.
  - RAMP_UP: gain = min(gain+step, GMAX). At GMAX go to RUN. If `enable` is low, go to RAMP_DOWN without stepping.
  - RUN: gain holds. If `enable` is low, go to RAMP_DOWN.
  - RAMP_DOWN: gain = max(gain−step, 0). At 0 go to IDLE. If `enable` is high, go to RAMP_UP without stepping.
  - `ramp_step`=0: gain holds and state holds in RAMP_UP/RAMP_DOWN.
- **Gain used per frame.** A frame is multiplied by the gain value after its own sync-edge update.
- **Arithmetic.** scaled = (x·{0,gain} + 2^(GW−1)) >>> GW, i.e. floor after adding half an LSB. The result is saturated symmetrically to ±(2^(OW−1)−1). X and Y are treated identically. No LSB truncation beyond the GW shift.
- **IDLE frames.** Frames are still processed in IDLE; the outputs are 0 and `out_valid` still strobes.
- **Watchdog:**
  - The counter clears on an accepted sync, otherwise increments, saturating at WD_CYCLES.
  - When the count reaches WD_CYCLES and state≠IDLE, `wd_fault` is set. Gain and `out_x`/`out_y` are forced to 0 on the next edge, state goes to IDLE, and any in-flight frame is discarded (no `out_valid`).
  - `wd_fault` clears only on a cycle with `enable` low. While it is set, the block stays IDLE regardless of syncs.
- **Reset mid-operation:** immediate return to reset values. The first accepted sync after release starts a fresh capture.

## Timing

- **Latency:** sync at cycle t. X is registered at t, Y at t+1. Products are registered at t+2. Round/saturate result and `out_valid` are registered at t+3, so `out_valid` is high during cycle t+3 only.
- **Output stability:** `out_x`/`out_y` hold between strobes. Both change on the same edge.
- **Minimum frame spacing:** 2 cycles. Frames back-to-back every 2 cycles are fully pipelined with one `out_valid` per frame.
- **Status outputs:** `gain` and `state` are registered and reflect the sync-edge update at t+1. `wd_fault` is registered.
- **Watchdog timing:** with the last accepted sync at cycle s, `wd_fault` is first high at s+WD_CYCLES, and the outputs read 0 one cycle later.

## Test plan

- **Ramp-up:** 8-cycle frames, X=1000, Y=−1000, `ramp_step`=16384, `enable` raised. Successive strobes give (250,−250), (500,−500), (750,−750), (1000,−1000). State goes 1,1,1,2 and gain ends at 65535.
- **Ramp-down:** from RUN, drop `enable`. Gain goes 49151, 32767, 16383, 0, with outputs (750,−750), (500,−500), (250,−250), (0,0), then state IDLE. Re-raising `enable` mid-ramp returns to RAMP_UP without stepping on that frame.
- **Saturation:** RUN with X=40000, Y=−131072 gives (32767,−32767). X=32767 gives 32766.
- **Latency/pipelining:** a sync every 2 cycles gives one `out_valid` per sync, each exactly 3 cycles after its sync. A second sync on t+1 is ignored, and its data is treated as Y.
- **Watchdog:** in RUN, stop syncs after cycle s. `wd_fault`=1 at s+64, outputs 0 at s+65, state 0. Resumed syncs with `enable` high keep IDLE. One cycle of `enable` low clears the fault, and the next sync starts RAMP_UP.
- **Reset:** pulse `rst_n` low mid-RAMP_UP. All outputs read 0 asynchronously. After release, the ramp restarts from gain 0.
